// File: rtl/chart_read_arbiter_pkg.sv
// Shared types and constants for the chart read arbiter: chart record layout,
// arbiter state encoding and the chart-id range check.
package chart_read_arbiter_pkg;

   localparam int NAME_LEN      = 4;
   localparam int MAX_CHART_DEF = 4;

   typedef logic [7:0] chart_id_t;

   // One chart record as delivered by chart storage.
   typedef struct packed {
      logic [NAME_LEN-1:0][7:0] name;
      logic [7:0]               bpm;
      logic [7:0]               n_notes;
   } chart_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Id 0 is free play and is a legal read; anything above max_id is rejected.
   function automatic logic id_valid(input chart_id_t id, input int max_id);
      return (int'(id) <= max_id);
   endfunction

endpackage

// File: rtl/chart_read_arbiter_if.sv
// Bundle between requesters, the arbiter and external chart storage.
interface chart_read_arbiter_if #(
   parameter int N_REQ = 3
) ();
   import chart_read_arbiter_pkg::*;

   // Handshake: a requester raises req[i] with a stable req_chart_id[i] and
   // holds it until rsp_valid[i] pulses for one cycle; that pulse is the only
   // acknowledge. mem_chart is valid MEM_LAT cycles after mem_chart_id moves.
   logic [N_REQ-1:0]      req;
   logic [N_REQ-1:0][7:0] req_chart_id;
   logic [N_REQ-1:0]      rsp_valid;
   logic                  rsp_err;
   chart_t                rsp_chart;
   logic                  busy;
   logic [7:0]            mem_chart_id;
   chart_t                mem_chart;
   logic [1:0]            dbg_state;

   modport master (
      output req, req_chart_id, mem_chart,
      input  rsp_valid, rsp_err, rsp_chart, busy, mem_chart_id, dbg_state
   );

   modport slave (
      input  req, req_chart_id, mem_chart,
      output rsp_valid, rsp_err, rsp_chart, busy, mem_chart_id, dbg_state
   );

endinterface

// File: rtl/chart_read_arbiter_rr_grant.sv
// Round-robin grant: first active request searching upward from the one after
// last_i, wrapping at N.
module rr_grant #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   int cand;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = 0;
      for (int k = 1; k <= N; k++) begin
         cand = (int'(last_i) + k) % N;
         if (!any_o && req_i[cand]) begin
            any_o         = 1'b1;
            idx_o         = IW'(cand);
            grant_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/chart_read_arbiter.sv
// Arbitrates chart reads from several requesters onto one external chart
// storage port, with a one-entry cache of the last chart fetched.
module chart_read_arbiter
   import chart_read_arbiter_pkg::*;
#(
   parameter int N_REQ     = 3,
   parameter int MEM_LAT   = 1,
   parameter int MAX_CHART = MAX_CHART_DEF
) (
   input  logic                prog_clk,
   input  logic                rst,
   chart_read_arbiter_if.slave bus
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(MEM_LAT + 1);

   logic [1:0]       state_q, state_d;
   logic [N_REQ-1:0] win_oh_q, win_oh_d;
   logic [IW-1:0]    win_idx_q, win_idx_d;
   logic [IW-1:0]    last_q, last_d;
   chart_id_t        id_q, id_d;
   chart_id_t        cache_id_q, cache_id_d;
   chart_id_t        mem_id_q, mem_id_d;
   logic             err_q, err_d;
   logic             cache_valid_q, cache_valid_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   chart_t           rsp_chart_q, rsp_chart_d;

   logic [N_REQ-1:0] g_oh;
   logic [IW-1:0]    g_idx;
   logic             g_any;
   chart_id_t        id_sel;

   rr_grant #(
      .N  (N_REQ),
      .IW (IW)
   ) u_rr_grant (
      .req_i   (bus.req),
      .last_i  (last_q),
      .grant_o (g_oh),
      .idx_o   (g_idx),
      .any_o   (g_any)
   );

   assign id_sel = bus.req_chart_id[g_idx];

   always_comb begin
      state_d       = state_q;
      win_oh_d      = win_oh_q;
      win_idx_d     = win_idx_q;
      last_d        = last_q;
      id_d          = id_q;
      cache_id_d    = cache_id_q;
      mem_id_d      = mem_id_q;
      err_d         = err_q;
      cache_valid_d = cache_valid_q;
      cnt_d         = cnt_q;
      rsp_chart_d   = rsp_chart_q;

      case (state_q)
         ST_IDLE: begin
            if (g_any) begin
               win_oh_d  = g_oh;
               win_idx_d = g_idx;
               id_d      = id_sel;
               if (!id_valid(id_sel, MAX_CHART)) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else if (cache_valid_q && (id_sel == cache_id_q)) begin
                  err_d   = 1'b0;
                  state_d = ST_RESP;
               end else begin
                  // Only a miss moves the storage address.
                  err_d    = 1'b0;
                  mem_id_d = id_sel;
                  cnt_d    = '0;
                  state_d  = ST_WAIT;
               end
            end
         end

         ST_WAIT: begin
            // Counter stops at MEM_LAT and leaves WAIT, so it cannot wrap.
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(MEM_LAT)) begin
               rsp_chart_d   = bus.mem_chart;
               cache_id_d    = id_q;
               cache_valid_d = 1'b1;
               state_d       = ST_RESP;
            end
         end

         ST_RESP: begin
            last_d  = win_idx_q;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge prog_clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         win_oh_q      <= '0;
         win_idx_q     <= '0;
         last_q        <= IW'(N_REQ - 1);
         id_q          <= '0;
         cache_id_q    <= '0;
         mem_id_q      <= '0;
         err_q         <= 1'b0;
         cache_valid_q <= 1'b0;
         cnt_q         <= '0;
         rsp_chart_q   <= '0;
      end else begin
         state_q       <= state_d;
         win_oh_q      <= win_oh_d;
         win_idx_q     <= win_idx_d;
         last_q        <= last_d;
         id_q          <= id_d;
         cache_id_q    <= cache_id_d;
         mem_id_q      <= mem_id_d;
         err_q         <= err_d;
         cache_valid_q <= cache_valid_d;
         cnt_q         <= cnt_d;
         rsp_chart_q   <= rsp_chart_d;
      end
   end

   assign bus.rsp_valid    = (state_q == ST_RESP) ? win_oh_q : '0;
   assign bus.rsp_err      = (state_q == ST_RESP) && err_q;
   assign bus.rsp_chart    = rsp_chart_q;
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.mem_chart_id = mem_id_q;
   assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_chart_read_arbiter.sv
// Bench for chart_read_arbiter: a latency-countdown reference model checked
// every cycle on a MEM_LAT=1 instance, plus directed checks on a MEM_LAT=3 one.
module tb_chart_read_arbiter;
   import chart_read_arbiter_pkg::*;

   localparam int LAT1 = 1;
   localparam int LAT3 = 3;

   logic prog_clk = 1'b0;
   logic rst;
   logic rst3;

   always #5 prog_clk = ~prog_clk;

   chart_read_arbiter_if #(.N_REQ(3)) bus ();
   chart_read_arbiter_if #(.N_REQ(3)) bus3 ();

   chart_read_arbiter #(.N_REQ(3), .MEM_LAT(LAT1), .MAX_CHART(4)) u_dut (
      .prog_clk (prog_clk),
      .rst      (rst),
      .bus      (bus)
   );

   chart_read_arbiter #(.N_REQ(3), .MEM_LAT(LAT3), .MAX_CHART(4)) u_dut3 (
      .prog_clk (prog_clk),
      .rst      (rst3),
      .bus      (bus3)
   );

   function automatic chart_t chart_of(input logic [7:0] id);
      chart_t c;
      c.name    = {8'h43, 8'h48, 8'h30 + id, 8'h5F};
      c.bpm     = 8'd100 + id * 8'd10;
      c.n_notes = id * 8'd7 + 8'd3;
      return c;
   endfunction

   // Storage models: zero-stage for latency 1, two address stages for latency 3.
   logic [7:0] a3_s1, a3_s2;
   assign bus.mem_chart = chart_of(bus.mem_chart_id);
   always @(posedge prog_clk) begin
      a3_s1 <= bus3.mem_chart_id;
      a3_s2 <= a3_s1;
   end
   assign bus3.mem_chart = chart_of(a3_s2);

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;
   logic [2:0] auto_drop;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: one outstanding transaction described by the number of
   // edges left until its data lands, and a flag for the response cycle.
   bit         m_resp   = 1'b0;
   int         m_wait   = 0;
   int         m_winner = 0;
   int         m_last   = 2;
   bit         m_err    = 1'b0;
   bit         m_cvalid = 1'b0;
   logic [7:0] m_cid    = '0;
   logic [7:0] m_mem_id = '0;
   chart_t     m_chart  = '0;

   task automatic model_step();
      bit         found;
      logic [7:0] id;
      if (rst) begin
         m_resp = 0; m_wait = 0; m_last = 2; m_err = 0;
         m_cvalid = 0; m_mem_id = '0; m_chart = '0;
      end else if (m_resp) begin
         m_last = m_winner;
         m_resp = 0;
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) begin
            m_chart  = chart_of(m_mem_id);
            m_cid    = m_mem_id;
            m_cvalid = 1;
            m_resp   = 1;
         end
      end else begin
         found = 0;
         for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_last + k) % 3;
            if (!found && bus.req[c]) begin
               found = 1;
               m_winner = c;
            end
         end
         if (found) begin
            id = bus.req_chart_id[m_winner];
            if (id > 8'd4) begin
               m_err = 1; m_resp = 1;
            end else if (m_cvalid && id == m_cid) begin
               m_err = 0; m_resp = 1;
            end else begin
               m_err = 0; m_mem_id = id; m_wait = LAT1;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge prog_clk);
      model_step();
   end

   initial forever begin
      @(negedge prog_clk);
      if (chk_en) begin
         chk("m_rsp_valid", bus.rsp_valid, m_resp ? (3'b001 << m_winner) : 3'b000);
         chk("m_rsp_err", bus.rsp_err, m_resp && m_err);
         chk("m_busy", bus.busy, m_resp || (m_wait > 0));
         chk("m_mem_chart_id", bus.mem_chart_id, m_mem_id);
         chk("m_rsp_chart", bus.rsp_chart, m_chart);
      end
   end

   // Steps until a response pulse; lat counts edges from the grant edge.
   task automatic wait_rsp(input int lat0, output int lat, output logic [2:0] rv,
                           output logic err, output chart_t ch);
      lat = lat0; rv = '0; err = 1'b0; ch = '0;
      for (int c = 0; c < 10; c++) begin
         @(posedge prog_clk);
         lat++;
         @(negedge prog_clk);
         if (bus.rsp_valid != 3'b000) begin
            rv = bus.rsp_valid; err = bus.rsp_err; ch = bus.rsp_chart;
            break;
         end
      end
      if (rv == 3'b000) begin
         total++; bad++;
         $display("FAIL wait_rsp timeout actual=none required=pulse");
         lat = 0;
      end
      @(posedge prog_clk); #1;
      bus.req = bus.req & ~(rv & auto_drop);
   endtask

   int         lat;
   logic [2:0] rv;
   logic       err;
   chart_t     ch;
   logic [2:0] exp_rv [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
   logic [7:0] exp_id [4] = '{8'd1, 8'd3, 8'd4, 8'd1};
   logic       seen;

   initial begin
      rst = 1'b1; rst3 = 1'b1; auto_drop = 3'b111;
      bus.req = '0;  bus.req_chart_id = '0;
      bus3.req = '0; bus3.req_chart_id = '0;
      repeat (2) @(posedge prog_clk);
      #1 chk_en = 1'b1;
      @(negedge prog_clk);
      chk("rst_rsp_valid", bus.rsp_valid, 3'b000);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_mem_id", bus.mem_chart_id, 8'd0);
      chk("rst_rsp_chart", bus.rsp_chart, 48'd0);
      @(posedge prog_clk); #1;
      rst = 1'b0; rst3 = 1'b0;

      // Single miss from requester 0, id 2.
      bus.req_chart_id[0] = 8'd2; bus.req = 3'b001;
      @(posedge prog_clk);
      @(negedge prog_clk);
      chk("miss_grant_mem_id", bus.mem_chart_id, 8'd2);
      chk("miss_grant_busy", bus.busy, 1'b1);
      wait_rsp(1, lat, rv, err, ch);
      chk("miss_lat", lat, 2);
      chk("miss_rv", rv, 3'b001);
      chk("miss_err", err, 1'b0);
      chk("miss_bpm", ch.bpm, 8'd120);
      chk("miss_notes", ch.n_notes, 8'd17);
      chk("miss_name", ch.name, 32'h4348325F);

      // Cache hit from requester 1.
      bus.req_chart_id[1] = 8'd2; bus.req = bus.req | 3'b010;
      wait_rsp(0, lat, rv, err, ch);
      chk("hit_lat", lat, 1);
      chk("hit_rv", rv, 3'b010);
      chk("hit_mem_id", bus.mem_chart_id, 8'd2);
      chk("hit_chart", ch, chart_of(8'd2));

      // Invalid id from requester 2.
      bus.req_chart_id[2] = 8'd7; bus.req = bus.req | 3'b100;
      wait_rsp(0, lat, rv, err, ch);
      chk("inv_lat", lat, 1);
      chk("inv_rv", rv, 3'b100);
      chk("inv_err", err, 1'b1);
      chk("inv_chart", ch, chart_of(8'd2));
      chk("inv_mem_id", bus.mem_chart_id, 8'd2);

      // Contention with all three held high.
      auto_drop = 3'b000;
      bus.req_chart_id[0] = 8'd1; bus.req_chart_id[1] = 8'd3; bus.req_chart_id[2] = 8'd4;
      bus.req = 3'b111;
      for (int i = 0; i < 4; i++) begin
         wait_rsp(0, lat, rv, err, ch);
         chk($sformatf("cont%0d_rv", i), rv, exp_rv[i]);
         chk($sformatf("cont%0d_lat", i), lat, 2);
         chk($sformatf("cont%0d_chart", i), ch, chart_of(exp_id[i]));
      end
      bus.req = 3'b000; auto_drop = 3'b111;

      // Invalid id must leave the cache holding chart 1.
      bus.req_chart_id[2] = 8'd9; bus.req = 3'b100;
      wait_rsp(0, lat, rv, err, ch);
      chk("inv2_err", err, 1'b1);
      chk("inv2_rv", rv, 3'b100);
      bus.req_chart_id[1] = 8'd1; bus.req = 3'b010;
      wait_rsp(0, lat, rv, err, ch);
      chk("hit2_lat", lat, 1);
      chk("hit2_chart", ch, chart_of(8'd1));

      // Withdrawn request with an id change mid-flight; latched id wins.
      bus.req_chart_id[0] = 8'd3; bus.req = 3'b001;
      @(posedge prog_clk); #1;
      bus.req_chart_id[0] = 8'd4; bus.req_chart_id[2] = 8'd0; bus.req = 3'b100;
      wait_rsp(1, lat, rv, err, ch);
      chk("wd_rv", rv, 3'b001);
      chk("wd_chart", ch, chart_of(8'd3));
      wait_rsp(0, lat, rv, err, ch);
      chk("wd_next_rv", rv, 3'b100);
      chk("wd_next_lat", lat, 2);
      chk("wd_next_chart", ch, chart_of(8'd0));

      // After reset the lowest active index wins first.
      rst = 1'b1;
      @(posedge prog_clk); #1;
      rst = 1'b0;
      bus.req_chart_id[1] = 8'd1; bus.req_chart_id[2] = 8'd3; bus.req = 3'b110;
      wait_rsp(0, lat, rv, err, ch);
      chk("post_rst_first", rv, 3'b010);
      chk("post_rst_lat", lat, 2);
      wait_rsp(0, lat, rv, err, ch);
      chk("post_rst_second", rv, 3'b100);

      // Latency-3 instance: miss latency, then reset in the middle of WAIT.
      bus3.req_chart_id[0] = 8'd1; bus3.req = 3'b001;
      lat = 0; rv = '0; ch = '0;
      for (int c = 1; c <= 8; c++) begin
         @(posedge prog_clk);
         @(negedge prog_clk);
         if (bus3.rsp_valid != 3'b000) begin
            lat = c; rv = bus3.rsp_valid; ch = bus3.rsp_chart;
            break;
         end
      end
      @(posedge prog_clk); #1;
      bus3.req = 3'b000;
      chk("l3_lat", lat, 4);
      chk("l3_rv", rv, 3'b001);
      chk("l3_chart", ch, chart_of(8'd1));

      @(posedge prog_clk); #1;
      bus3.req_chart_id[0] = 8'd2; bus3.req = 3'b001;
      @(posedge prog_clk);
      @(negedge prog_clk);
      chk("l3_wait_busy", bus3.busy, 1'b1);
      chk("l3_wait_mem_id", bus3.mem_chart_id, 8'd2);
      @(posedge prog_clk); #1;
      rst3 = 1'b1; bus3.req = 3'b000;
      @(posedge prog_clk);
      @(negedge prog_clk);
      chk("l3_rst_rv", bus3.rsp_valid, 3'b000);
      chk("l3_rst_busy", bus3.busy, 1'b0);
      chk("l3_rst_err", bus3.rsp_err, 1'b0);
      chk("l3_rst_mem_id", bus3.mem_chart_id, 8'd0);
      chk("l3_rst_chart", bus3.rsp_chart, 48'd0);
      chk("l3_rst_state", bus3.dbg_state, 2'd0);
      @(posedge prog_clk); #1;
      rst3 = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge prog_clk);
         if (bus3.rsp_valid != 3'b000) seen = 1'b1;
      end
      chk("l3_no_pulse_after_abort", seen, 1'b0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
